// File: rtl/fpsu_alt_feed.sv
// Alternate-operand feed queue for the FPU: a small FIFO whose head entry is
// presented on registered outputs, with a sticky underflow flag.
module fpsu_alt_feed #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_pair,
    output logic                     in_ready,
    input  logic                     alt_req,
    input  logic                     flush,
    output logic [WIDTH-1:0]         ALTDATA0,
    output logic [1:0]               ALT_INP,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] pair_mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count_next;
    logic             push;
    logic             pop;
    logic             bypass;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = alt_req && (count != '0);

    // The head registers are loaded from the post-update state; when the queue
    // drains to empty in the same cycle a word arrives, that word goes straight
    // to the head since it is not yet in storage.
    always_comb begin
        rd_next    = rd_ptr + AW'(pop);
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);
        bypass     = push && (count == (AW+1)'(pop));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ALT_INP  <= 2'b00;
            ALTDATA0 <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ALT_INP <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next == '0) begin
                ALT_INP <= 2'b00;
            end else if (bypass) begin
                ALT_INP  <= {in_pair, 1'b1};
                ALTDATA0 <= in_data;
            end else begin
                ALT_INP  <= {pair_mem[rd_next], 1'b1};
                ALTDATA0 <= data_mem[rd_next];
            end
        end
    end

    // Sticky: survives flush, only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_underflow <= 1'b0;
        end else if (alt_req && (count == '0)) begin
            err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr] <= in_data;
            pair_mem[wr_ptr] <= in_pair;
        end
    end

endmodule

// File: doc/fpsu_alt_feed.md
FPSU_ALT_FEED -- requirements
Module: fpsu_alt_feed

Interface
REQ-001 The block SHALL have parameter WIDTH, default 68, giving the alternate-data word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the queue entry count; only the power-of-two values 2, 4 and 8 are legal.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the alternate operand word.
REQ-007 The block SHALL have port in_pair, input, 1 bit: the word carries two packed single-precision lanes.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the queue can accept a word this cycle.
REQ-009 The block SHALL have port alt_req, input, 1 bit: the FPU consumes the head entry this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all entries.
REQ-011 The block SHALL have port ALTDATA0, output, WIDTH bits: the head entry data, registered.
REQ-012 The block SHALL have port ALT_INP, output, 2 bits: bit0 = head valid, bit1 = head in_pair flag; both registered.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits: the current occupancy.
REQ-014 The block SHALL have port err_underflow, output, 1 bit: sticky; set when alt_req is asserted while the queue is empty.

Function
REQ-015 The block SHALL be a DEPTH-entry FIFO with binary read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 A push SHALL occur when in_valid and in_ready are both 1.
REQ-017 in_ready SHALL equal (count != DEPTH); it is combinational from state only and never depends on alt_req.
REQ-018 A pop SHALL occur when alt_req is 1 and count != 0.
REQ-019 When alt_req is asserted with count == 0, no pop SHALL occur, err_underflow SHALL be set, and the pointers SHALL remain unchanged.
REQ-020 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 When count == DEPTH, the push is refused (in_ready = 0); a pop that cycle SHALL reduce count to DEPTH-1.
REQ-022 Head latency SHALL be: a push into an empty queue in cycle N gives ALT_INP[0] = 1 and ALTDATA0 = in_data in cycle N+1.
REQ-023 After a pop in cycle N, ALTDATA0 and ALT_INP SHALL show the next entry in cycle N+1, or ALT_INP = 0 with ALTDATA0 holding its last value if the queue is now empty.
REQ-024 flush SHALL take priority over push and pop in the same cycle: next cycle count = 0, both pointers = 0, ALT_INP = 0, and the pushed word is dropped.
REQ-025 flush SHALL NOT clear err_underflow; only rst clears it.
REQ-026 Entry storage SHALL be written only on push; it is not reset.
REQ-027 count SHALL never exceed DEPTH or go below 0 under any input combination.

Reset
REQ-028 While rst = 0, the block SHALL hold count = 0, both pointers = 0, ALT_INP = 2'b00, ALTDATA0 = 0, err_underflow = 0, and therefore in_ready = 1.
REQ-029 Assertion of rst mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-030 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Scenario: push 0x1_0000_0001 with in_pair = 1 into an empty queue -> next cycle ALT_INP = 2'b11, ALTDATA0 = 0x1_0000_0001, count = 1.
REQ-032 Scenario: push 4 words A, B, C, D, then keep in_valid asserted -> in_ready = 0 and count = 4; then alt_req is pulsed 4 times -> ALTDATA0 sequence A, B, C, D, then ALT_INP[0] = 0.
REQ-033 Scenario: with count = 4, assert in_valid and alt_req together -> push refused, count = 3; the next cycle in_ready = 1.
REQ-034 Scenario: with count = 2, push and pop in the same cycle, repeated over 10 cycles -> count stays 2, FIFO order is preserved, and the pointers wrap with no loss.
REQ-035 Scenario: alt_req asserted with count = 0 -> err_underflow = 1 and count = 0; a later flush leaves err_underflow at 1.
REQ-036 Scenario: with count = 3, assert flush together with in_valid and alt_req -> next cycle count = 0 and ALT_INP = 0; then drive rst = 0 asynchronously between edges -> err_underflow = 0 and in_ready = 1 immediately.
